// File: rtl/param_counter.sv
// Parametrised up/down counter with parallel load, enable prescaler,
// wrap-or-saturate limit handling, a one-cycle limit pulse and a sticky overflow flag.
module param_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = (1 << WIDTH) - 1,
    parameter int PRESCALE  = 1,
    parameter int SATURATE  = 0
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             up_down_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             clear_ovf_i,
    output logic [WIDTH-1:0] counter_out_o,
    output logic             terminal_count_o,
    output logic             wrap_pulse_o,
    output logic             overflow_o
);

    localparam int               PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VALUE);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             step_s, at_max_s, at_zero_s, limit_s;
    logic [WIDTH-1:0] load_clamped_s;

    assign at_max_s       = (cnt_q == MAX_C);
    assign at_zero_s      = (cnt_q == {WIDTH{1'b0}});
    assign step_s         = enable_i && (presc_q == PS_LAST);
    assign load_clamped_s = (load_value_i > MAX_C) ? MAX_C : load_value_i;

    // Next-state: load beats a due step; a step at a limit raises a limit event.
    always_comb begin
        cnt_d   = cnt_q;
        presc_d = presc_q;
        limit_s = 1'b0;
        if (load_i) begin
            cnt_d   = load_clamped_s;
            presc_d = {PS_W{1'b0}};
        end else if (step_s) begin
            presc_d = {PS_W{1'b0}};
            if (up_down_i) begin
                if (at_max_s) begin
                    limit_s = 1'b1;
                    cnt_d   = (SATURATE != 0) ? MAX_C : {WIDTH{1'b0}};
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (at_zero_s) begin
                    limit_s = 1'b1;
                    cnt_d   = (SATURATE != 0) ? {WIDTH{1'b0}} : MAX_C;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end else if (enable_i) begin
            presc_d = presc_q + PS_W'(1);
        end else begin
            presc_d = presc_q;
        end
    end

    // Limit pulse and sticky flag; a same-edge set beats the clear.
    always_comb begin
        wrap_d = limit_s;
        if (limit_s) begin
            ovf_d = 1'b1;
        end else if (clear_ovf_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q   <= {WIDTH{1'b0}};
            presc_q <= {PS_W{1'b0}};
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign counter_out_o    = cnt_q;
    assign wrap_pulse_o     = wrap_q;
    assign overflow_o       = ovf_q;
    assign terminal_count_o = up_down_i ? at_max_s : at_zero_s;

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: four parameter sets share one stimulus bus,
// each directed vector pushes its hand-computed response for one instance.
module tb_param_counter;

    logic       clk = 1'b0;
    logic       rst, en, ud, ld, clr;
    logic [4:0] lv;

    logic [3:0] c0, c2, c3;
    logic [4:0] c1;
    logic       t0, t1, t2, t3, w0, w1, w2, w3, o0, o1, o2, o3;

    always #5 clk = ~clk;

    param_counter u0 (.clock_i(clk), .reset_i(rst), .enable_i(en), .up_down_i(ud),
        .load_i(ld), .load_value_i(lv[3:0]), .clear_ovf_i(clr), .counter_out_o(c0),
        .terminal_count_o(t0), .wrap_pulse_o(w0), .overflow_o(o0));

    param_counter #(.WIDTH(5), .MAX_VALUE(9)) u1 (.clock_i(clk), .reset_i(rst),
        .enable_i(en), .up_down_i(ud), .load_i(ld), .load_value_i(lv), .clear_ovf_i(clr),
        .counter_out_o(c1), .terminal_count_o(t1), .wrap_pulse_o(w1), .overflow_o(o1));

    param_counter #(.SATURATE(1)) u2 (.clock_i(clk), .reset_i(rst), .enable_i(en),
        .up_down_i(ud), .load_i(ld), .load_value_i(lv[3:0]), .clear_ovf_i(clr),
        .counter_out_o(c2), .terminal_count_o(t2), .wrap_pulse_o(w2), .overflow_o(o2));

    param_counter #(.PRESCALE(3)) u3 (.clock_i(clk), .reset_i(rst), .enable_i(en),
        .up_down_i(ud), .load_i(ld), .load_value_i(lv[3:0]), .clear_ovf_i(clr),
        .counter_out_o(c3), .terminal_count_o(t3), .wrap_pulse_o(w3), .overflow_o(o3));

    typedef struct packed {
        logic [1:0] inst;
        logic [4:0] cnt;
        logic       tc;
        logic       wr;
        logic       ov;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    exp_t       mx;
    logic [4:0] ac;
    logic       at, aw, ao;

    // Monitor: every edge that has a pending expectation is checked 2 ns after it.
    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            mx = sb.pop_front();
            case (mx.inst)
                2'd0:    begin ac = {1'b0, c0}; at = t0; aw = w0; ao = o0; end
                2'd1:    begin ac = c1;         at = t1; aw = w1; ao = o1; end
                2'd2:    begin ac = {1'b0, c2}; at = t2; aw = w2; ao = o2; end
                default: begin ac = {1'b0, c3}; at = t3; aw = w3; ao = o3; end
            endcase
            n_vec++;
            if ({ac, at, aw, ao} !== {mx.cnt, mx.tc, mx.wr, mx.ov}) begin
                n_bad++;
                $display("FAIL vec%0d dut%0d: got cnt=%0d tc=%b wrap=%b ovf=%b, need cnt=%0d tc=%b wrap=%b ovf=%b",
                         n_vec, mx.inst, ac, at, aw, ao, mx.cnt, mx.tc, mx.wr, mx.ov);
            end
        end
    end

    task automatic vec(input int k, input logic r, input logic e, input logic u,
                       input logic l, input logic [4:0] v, input logic c,
                       input logic [4:0] ec, input logic et, input logic ew, input logic eo);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; ud = u; ld = l; lv = v; clr = c;
        x.inst = 2'(k); x.cnt = ec; x.tc = et; x.wr = ew; x.ov = eo;
        sb.push_back(x);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ud = 1'b1; ld = 1'b0; lv = 5'd0; clr = 1'b0;

        // Default counter: reset, 20 up steps wrapping once, then reset clears overflow.
        vec(0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            vec(0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'(i % 16),
                (i % 16) == 15, i == 16, i >= 16);
        end
        vec(0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        // MAX_VALUE=9 counting down from 0, then clamped load versus due step.
        vec(1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        vec(1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd9, 1'b0, 1'b1, 1'b1);
        vec(1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd8, 1'b0, 1'b0, 1'b1);
        vec(1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd7, 1'b0, 1'b0, 1'b1);
        vec(1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        vec(1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd20, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        vec(1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
        vec(1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        vec(1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0);

        // Saturating counter: load 14, four up steps hold at 15, reset kills the pulse.
        vec(2, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
        vec(2, 1'b0, 1'b0, 1'b1, 1'b1, 5'd14, 1'b0, 5'd14, 1'b0, 1'b0, 1'b0);
        vec(2, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 5'd15, 1'b1, 1'b0, 1'b0);
        vec(2, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 5'd15, 1'b1, 1'b1, 1'b1);
        vec(2, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 5'd15, 1'b1, 1'b1, 1'b1);
        vec(2, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 5'd15, 1'b1, 1'b1, 1'b1);
        vec(2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0);

        // Prescale by 3 with an enable gap on edge 5; the prescaler holds across it.
        vec(3, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        vec(3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        vec(3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        vec(3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
        vec(3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
        vec(3, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
        vec(3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
        vec(3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
        vec(3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
        vec(3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);

        // Reset together with load at out=7 and prescaler=1; restart needs 3 enables.
        vec(3, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
        vec(3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
        vec(3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        vec(3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        vec(3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        vec(3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        en = 1'b0; ld = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, need 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
